// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Definitions shared by the intersection phase scheduler and its tick
//   generator:
//     - lamp codes for one 3-bit RGB head ({R,G,B} bit order)
//     - the phase encoding, which is visible on the scheduler's phase output
//     - the default clock and tick rates for the board build
// -----------------------------------------------------------------------------
package traffic_pkg;

  // Lamp codes for one head. Yellow is red and green lit together.
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b110;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // Phase encoding. 2'b11 is illegal; the scheduler recovers from it to
  // all-red on the next clock edge.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  // Board rates: a 100 MHz clock and a 10 ms scheduling tick.
  localparam int DEF_CLK_HZ  = 100_000_000;
  localparam int DEF_TICK_HZ = 100;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Divides the system clock down to the scheduler time base. A free-running
//   counter runs from 0 to CLK_HZ/TICK_HZ-1, and tick is high for exactly the
//   one cycle spent at the terminal count.
//   Ports:
//     clk_100MHz  in   system clock, posedge
//     rst         in   synchronous active-high reset; the counter restarts at 0
//     tick        out  one-cycle pulse every CLK_HZ/TICK_HZ clocks
// -----------------------------------------------------------------------------
module tick_gen
  import traffic_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ
) (
  input  logic clk_100MHz,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // NOTE: always use non-blocking (<=) for clocked state. Every register then
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk_100MHz) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//   Shares one green right-of-way among N_APP approaches on demand. Detector
//   requests are latched into pending bits and served in round-robin order.
//   Each green is followed by a yellow phase and then an all-red clearance
//   phase. All timing counts ticks from tick_gen.
//   Ports:
//     clk_100MHz  in   system clock, posedge
//     rst         in   synchronous active-high reset
//     req         in   [N_APP]     level vehicle detect per approach (already synchronised)
//     rgb         out  [3*N_APP]   lamp head for approach i on rgb[3i+2:3i]
//     active      out  [clog2(N)]  approach that holds, or last held, the right-of-way
//     phase       out  [2]         00 green, 01 yellow, 10 all-red
// -----------------------------------------------------------------------------
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int TICK_HZ   = DEF_TICK_HZ,
  parameter int N_APP     = 4,
  parameter int MIN_GREEN = 50,
  parameter int MAX_GREEN = 300,
  parameter int YELLOW_T  = 50,
  parameter int ALLRED_T  = 20
) (
  input  logic                       clk_100MHz,
  input  logic                       rst,
  input  logic [N_APP-1:0]           req,
  output logic [3*N_APP-1:0]         rgb,
  output logic [$clog2(N_APP)-1:0]   active,
  output logic [1:0]                 phase
);

  localparam int AW = $clog2(N_APP);
  localparam int TW = $clog2(MAX_GREEN + 1);

  logic               tick;
  phase_e             phase_q,   phase_d;
  logic [TW-1:0]      timer_q,   timer_d;
  logic [N_APP-1:0]   pending_q, pending_d;
  logic [AW-1:0]      active_q,  active_d;
  logic [3*N_APP-1:0] rgb_q,     rgb_d;

  logic [N_APP-1:0]   clr;
  logic [N_APP-1:0]   req_eff;
  logic [TW-1:0]      timer_sat;
  logic [AW-1:0]      grant;
  logic               other;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .tick       (tick)
  );

  function automatic logic [N_APP-1:0] onehot(input logic [AW-1:0] idx);
    return {{(N_APP-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search: the first pending approach after cur, wrapping round.
  // cur itself is the last candidate. The scan runs from the farthest offset
  // to the nearest, so the nearest hit is the one left in pick.
  function automatic logic [AW-1:0] rr_pick(input logic [N_APP-1:0] pend,
                                            input logic [AW-1:0]    cur);
    logic [AW-1:0] pick;
    int            idx;
    pick = cur;
    for (int off = N_APP; off >= 1; off--) begin
      idx = (int'(cur) + off) % N_APP;
      if (pend[idx]) pick = AW'(idx);
    end
    return pick;
  endfunction

  // NOTE: every signal written in always_comb gets a default on entry.
  // Any path that skips an assignment would otherwise infer a latch.
  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q;
    active_d  = active_q;
    clr       = '0;
    grant     = rr_pick(pending_q, active_q);
    other     = |(pending_q & ~onehot(active_q));
    timer_sat = (timer_q == TW'(MAX_GREEN)) ? timer_q : timer_q + 1'b1;

    case (phase_q)
      PH_ALLRED: begin
        if (tick) begin
          // Once the clearance time is up the timer keeps counting until it
          // saturates. With no demand, all-red holds and is re-checked on
          // every tick.
          if (timer_q >= TW'(ALLRED_T - 1) && |pending_q) begin
            phase_d  = PH_GREEN;
            active_d = grant;
            timer_d  = '0;
            clr      = onehot(grant);
          end else begin
            timer_d  = timer_sat;
          end
        end
      end
      PH_GREEN: begin
        if (tick) begin
          // Green yields only when another approach is waiting. A busy
          // detector on the green approach extends green up to MAX_GREEN.
          if (other && timer_q >= TW'(MIN_GREEN - 1) &&
              (!req[active_q] || timer_q >= TW'(MAX_GREEN - 1))) begin
            phase_d = PH_YELLOW;
            timer_d = '0;
          end else begin
            timer_d = timer_sat;
          end
        end
      end
      PH_YELLOW: begin
        if (tick) begin
          if (timer_q == TW'(YELLOW_T - 1)) begin
            phase_d = PH_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_sat;
          end
        end
      end
      default: begin
        // Illegal encoding: drop straight to all-red, without waiting for a tick.
        phase_d = PH_ALLRED;
        timer_d = '0;
      end
    endcase

    // While an approach is green, its own detector does not queue a repeat
    // service. On the grant edge the clear wins over a simultaneous request.
    req_eff = req;
    if (phase_q == PH_GREEN) req_eff[active_q] = 1'b0;
    pending_d = (pending_q | req_eff) & ~clr;

    // The lamps are decoded from the next state, so they register on the same
    // edge as phase and active.
    rgb_d = {N_APP{LAMP_RED}};
    if (phase_d == PH_GREEN)  rgb_d[3*int'(active_d) +: 3] = LAMP_GREEN;
    if (phase_d == PH_YELLOW) rgb_d[3*int'(active_d) +: 3] = LAMP_YELLOW;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      phase_q   <= PH_ALLRED;
      timer_q   <= '0;
      pending_q <= '0;
      active_q  <= AW'(N_APP - 1);
      rgb_q     <= {N_APP{LAMP_RED}};
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb    = rgb_q;
  assign active = active_q;
  assign phase  = phase_q;

endmodule
